// File: rtl/ast_downconv_64to8.sv
// ast_downconv_64to8: Avalon-ST 64-bit to 8-bit width down-converter.
//
// A single holding register keeps one sink beat. Its bytes go out one per
// source handshake, most-significant byte first. The sink is ready again in
// the same cycle that the last byte of the held beat is taken, so packets
// stream with no bubble between beats.
//
// Sink beats that break framing raise a one-cycle framing_err pulse:
//   - a beat without sop arriving outside a packet is accepted and dropped;
//   - a sop beat arriving inside a packet starts a new packet. The previous
//     packet is left without an eop.
//
// Optional build macro AST_DOWNCONV_STATS_EN adds the pkt_count and
// byte_count statistics outputs.
//
// state | meaning
// EMPTY | no beat held; sink ready
// EMIT  | beat held; byte idx_q presented on the source
module ast_downconv_64to8 (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] asi_in_data,
    input  logic        asi_in_valid,
    output logic        asi_in_ready,
    input  logic        asi_in_sop,
    input  logic        asi_in_eop,
    input  logic [2:0]  asi_in_empty,
    input  logic [5:0]  asi_in_error,
    output logic [7:0]  aso_out_data,
    output logic        aso_out_valid,
    input  logic        aso_out_ready,
    output logic        aso_out_sop,
    output logic        aso_out_eop,
    output logic [5:0]  aso_out_error,
`ifdef AST_DOWNCONV_STATS_EN
    output logic [31:0] pkt_count,
    output logic [31:0] byte_count,
`endif
    output logic        framing_err
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_EMIT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] data_q, data_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  last_q, last_d;
    logic        bsop_q, bsop_d;
    logic        beop_q, beop_d;
    logic [5:0]  err_q, err_d;
    logic        in_pkt_q, in_pkt_d;
    logic        fe_q, fe_d;

    logic        out_hs;
    logic        last_hs;
    logic        ready_int;
    logic        accept;
    logic        drop_beat;
    logic [7:0]  byte_sel;

    // Handshake decode. Ready does not wait for reset to be released
    // internally; the port is masked below.
    always_comb begin
        out_hs    = aso_out_valid && aso_out_ready;
        last_hs   = out_hs && (idx_q == last_q);
        ready_int = (state_q == ST_EMPTY) || last_hs;
        accept    = asi_in_valid && ready_int;
        drop_beat = !asi_in_sop && !in_pkt_q;
    end

    assign asi_in_ready = ready_int && !reset;

    // Next-state and holding-register update.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        idx_d    = idx_q;
        last_d   = last_q;
        bsop_d   = bsop_q;
        beop_d   = beop_q;
        err_d    = err_q;
        in_pkt_d = in_pkt_q;
        fe_d     = 1'b0;

        if (out_hs) begin
            if (last_hs) begin
                state_d = ST_EMPTY;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end

        if (accept) begin
            if (drop_beat) begin
                // Orphan beat: accepted so the sink never stalls, then dropped.
                fe_d = 1'b1;
            end else begin
                state_d = ST_EMIT;
                data_d  = asi_in_data;
                idx_d   = 3'd0;
                last_d  = asi_in_eop ? (3'd7 - asi_in_empty) : 3'd7;
                bsop_d  = asi_in_sop;
                beop_d  = asi_in_eop;
                err_d   = asi_in_eop ? asi_in_error : 6'd0;
                fe_d    = asi_in_sop && in_pkt_q;
                if (asi_in_eop) begin
                    in_pkt_d = 1'b0;
                end else if (asi_in_sop) begin
                    in_pkt_d = 1'b1;
                end
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            idx_q    <= 3'd0;
            last_q   <= 3'd0;
            bsop_q   <= 1'b0;
            beop_q   <= 1'b0;
            err_q    <= 6'd0;
            in_pkt_q <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            bsop_q   <= bsop_d;
            beop_q   <= beop_d;
            err_q    <= err_d;
            in_pkt_q <= in_pkt_d;
            fe_q     <= fe_d;
        end
    end

    // Beat payload needs no reset; it is only observed while a beat is held.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    // Byte lane select: byte 0 is the most significant byte of the beat.
    always_comb begin
        byte_sel = 8'd0;
        case (idx_q)
            3'd0: byte_sel = data_q[63:56];
            3'd1: byte_sel = data_q[55:48];
            3'd2: byte_sel = data_q[47:40];
            3'd3: byte_sel = data_q[39:32];
            3'd4: byte_sel = data_q[31:24];
            3'd5: byte_sel = data_q[23:16];
            3'd6: byte_sel = data_q[15:8];
            3'd7: byte_sel = data_q[7:0];
            default: byte_sel = 8'd0;
        endcase
    end

    // Source outputs come straight from the held beat. They stay stable
    // under backpressure because idx_q only moves on a handshake.
    always_comb begin
        aso_out_valid = (state_q == ST_EMIT);
        aso_out_data  = byte_sel;
        aso_out_sop   = aso_out_valid && bsop_q && (idx_q == 3'd0);
        aso_out_eop   = aso_out_valid && beop_q && (idx_q == last_q);
        aso_out_error = aso_out_eop ? err_q : 6'd0;
    end

    assign framing_err = fe_q;

`ifdef AST_DOWNCONV_STATS_EN
    logic [31:0] pkt_count_q;
    logic [31:0] byte_count_q;

    // Statistics: one byte per source handshake, one packet per eop byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_q  <= 32'd0;
            byte_count_q <= 32'd0;
        end else if (out_hs) begin
            byte_count_q <= byte_count_q + 32'd1;
            if (aso_out_eop) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
        end
    end

    assign pkt_count  = pkt_count_q;
    assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_ast_downconv_64to8.sv
// Testbench for ast_downconv_64to8.
// The reference model expands each accepted beat into a queue of expected
// source bytes. Every cycle the DUT's source outputs must match the head of
// that queue, and they must stay on the same head while stalled. Directed
// tests then check logged results against literal values.
module tb_ast_downconv_64to8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] asi_in_data = 64'd0;
    logic        asi_in_valid = 1'b0;
    logic        asi_in_ready;
    logic        asi_in_sop = 1'b0;
    logic        asi_in_eop = 1'b0;
    logic [2:0]  asi_in_empty = 3'd0;
    logic [5:0]  asi_in_error = 6'd0;
    logic [7:0]  aso_out_data;
    logic        aso_out_valid;
    logic        aso_out_ready = 1'b1;
    logic        aso_out_sop;
    logic        aso_out_eop;
    logic [5:0]  aso_out_error;
    logic        framing_err;
`ifdef AST_DOWNCONV_STATS_EN
    logic [31:0] pkt_count;
    logic [31:0] byte_count;
`endif

    ast_downconv_64to8 dut (
        .clk           (clk),
        .reset         (reset),
        .asi_in_data   (asi_in_data),
        .asi_in_valid  (asi_in_valid),
        .asi_in_ready  (asi_in_ready),
        .asi_in_sop    (asi_in_sop),
        .asi_in_eop    (asi_in_eop),
        .asi_in_empty  (asi_in_empty),
        .asi_in_error  (asi_in_error),
        .aso_out_data  (aso_out_data),
        .aso_out_valid (aso_out_valid),
        .aso_out_ready (aso_out_ready),
        .aso_out_sop   (aso_out_sop),
        .aso_out_eop   (aso_out_eop),
        .aso_out_error (aso_out_error),
`ifdef AST_DOWNCONV_STATS_EN
        .pkt_count     (pkt_count),
        .byte_count    (byte_count),
`endif
        .framing_err   (framing_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic [5:0] err;
    } ent_t;

    ent_t        mq[$];
    bit          m_inpkt = 1'b0;
    bit          m_fe = 1'b0;
    logic [31:0] m_pkts = 32'd0;
    logic [31:0] m_bytes = 32'd0;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    bit   acc_now = 1'b0;
    int   acc_cyc = 0;
    int   fe_cnt = 0;
    bit   rdy_mode = 1'b0;
    bit   rdy_log [0:8191];
    ent_t got[$];
    int   got_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Source ready: held high, or toggled every cycle for backpressure tests.
    always @(posedge clk) begin
        #1;
        if (rdy_mode) aso_out_ready = ~aso_out_ready;
        else          aso_out_ready = 1'b1;
    end

    // Reference model and per-cycle compare.
    always @(negedge clk) begin
        ent_t f, e;
        bit   v, rdy, hs, acc;
        int   last;
        cyc++;
        v   = (mq.size() != 0);
        f   = v ? mq[0] : '0;
        rdy = !reset && (!v || (mq.size() == 1 && aso_out_ready));
        if (chk_en) begin
            chk("in_ready", asi_in_ready, rdy);
            chk("out_valid", aso_out_valid, v);
            if (v) chk("out_data", aso_out_data, f.d);
            chk("out_sop", aso_out_sop, f.sop);
            chk("out_eop", aso_out_eop, f.eop);
            chk("out_error", aso_out_error, f.err);
            chk("framing_err", framing_err, m_fe);
`ifdef AST_DOWNCONV_STATS_EN
            chk("pkt_count", pkt_count, m_pkts);
            chk("byte_count", byte_count, m_bytes);
`endif
        end
        if (cyc < 8192) rdy_log[cyc] = (asi_in_ready === 1'b1);
        if (framing_err === 1'b1) fe_cnt++;
        hs  = v && aso_out_ready && !reset;
        acc = asi_in_valid && rdy;
        acc_now = acc;
        if (acc) acc_cyc = cyc;
        if (reset) begin
            mq.delete();
            m_inpkt = 1'b0;
            m_fe    = 1'b0;
            m_pkts  = 32'd0;
            m_bytes = 32'd0;
        end else begin
            if (hs) begin
                got.push_back({aso_out_data, aso_out_sop, aso_out_eop, aso_out_error});
                got_cyc.push_back(cyc);
                m_bytes++;
                if (f.eop) m_pkts++;
                void'(mq.pop_front());
            end
            m_fe = 1'b0;
            if (acc) begin
                if (!asi_in_sop && !m_inpkt) begin
                    m_fe = 1'b1;
                end else begin
                    last = asi_in_eop ? 7 - int'(asi_in_empty) : 7;
                    for (int i = 0; i <= last; i++) begin
                        e.d   = asi_in_data[63 - 8*i -: 8];
                        e.sop = asi_in_sop && (i == 0);
                        e.eop = asi_in_eop && (i == last);
                        e.err = (asi_in_eop && (i == last)) ? asi_in_error : 6'd0;
                        mq.push_back(e);
                    end
                    m_fe = asi_in_sop && m_inpkt;
                    if (asi_in_eop)      m_inpkt = 1'b0;
                    else if (asi_in_sop) m_inpkt = 1'b1;
                end
            end
        end
    end

    // Present one beat and hold it until accepted. Entered and left #1 after posedge.
    task automatic send(input logic [63:0] d, input bit s, input bit e,
                        input logic [2:0] emp, input logic [5:0] err);
        bit done;
        done = 1'b0;
        asi_in_data  = d;
        asi_in_sop   = s;
        asi_in_eop   = e;
        asi_in_empty = emp;
        asi_in_error = err;
        asi_in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk);
            if (acc_now) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: beat %h not accepted, required acceptance within 200 cycles", d);
            @(posedge clk);
        end
        #1;
        asi_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 400 && !idle; k++) begin
            @(posedge clk);
            if (mq.size() == 0 && !asi_in_valid) idle = 1'b1;
        end
        if (!idle) begin
            total++;
            bad++;
            $display("FAIL wait_idle: %0d bytes still pending, required 0", mq.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp34 [0:4];
        int         fe0, nmis, nerr, c0;
        bit         hit;
        exp34 = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};

        // Reset state
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", aso_out_valid, 0);
        chk("rst_in_ready", asi_in_ready, 0);
        chk("rst_framing_err", framing_err, 0);
        chk("rst_out_eop", aso_out_eop, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single 5-byte packet
        got.delete(); got_cyc.delete();
        send(64'h0011223344556677, 1'b1, 1'b1, 3'd3, 6'd0);
        c0 = acc_cyc;
        wait_idle();
        chk("single_count", got.size(), 5);
        if (got.size() == 5) begin
            nmis = 0;
            for (int i = 0; i < 5; i++) if (got[i].d !== exp34[i]) nmis++;
            chk("single_bytes", nmis, 0);
            chk("single_sop", got[0].sop, 1);
            chk("single_eop", got[4].eop, 1);
            chk("single_first_latency", got_cyc[0] - c0, 1);
            chk("single_last_cycle", got_cyc[4] - c0, 5);
        end

        // Back-to-back 20-byte packet
        got.delete(); got_cyc.delete();
        send(64'h0102030405060708, 1'b1, 1'b0, 3'd0, 6'd0);
        send(64'h1112131415161718, 1'b0, 1'b0, 3'd5, 6'd0);
        send(64'h2122232425262728, 1'b0, 1'b1, 3'd4, 6'd0);
        wait_idle();
        chk("b2b_count", got.size(), 20);
        if (got.size() == 20) begin
            chk("b2b_consecutive", got_cyc[19] - got_cyc[0], 19);
            chk("b2b_last_byte", got[19].d, 8'h24);
            chk("b2b_last_eop", got[19].eop, 1);
            chk("b2b_byte8", got[8].d, 8'h11);
            chk("b2b_ready_cyc8", rdy_log[got_cyc[0] + 7], 1);
            chk("b2b_ready_cyc16", rdy_log[got_cyc[0] + 15], 1);
            chk("b2b_ready_cyc4", rdy_log[got_cyc[0] + 3], 0);
        end

        // Backpressure: source ready toggles every cycle
        got.delete(); got_cyc.delete();
        rdy_mode = 1'b1;
        send(64'h5051525354555657, 1'b1, 1'b0, 3'd0, 6'd0);
        send(64'h58595A5B5C5D5E5F, 1'b0, 1'b1, 3'd0, 6'd0);
        wait_idle();
        rdy_mode = 1'b0;
        chk("bp_count", got.size(), 16);
        nmis = 0;
        foreach (got[i]) if (got[i].d !== 8'(8'h50 + i)) nmis++;
        chk("bp_sequence", nmis, 0);

        // Framing: orphan beat, then sop inside a packet
        got.delete(); got_cyc.delete();
        fe0 = fe_cnt;
        send(64'hDEADBEEFCAFEF00D, 1'b0, 1'b0, 3'd0, 6'd0);
        wait_idle();
        chk("orphan_fe_pulses", fe_cnt - fe0, 1);
        chk("orphan_bytes", got.size(), 0);
        send(64'hA0A1A2A3A4A5A6A7, 1'b1, 1'b0, 3'd0, 6'd0);
        send(64'hB0B1B2B3B4B5B6B7, 1'b1, 1'b1, 3'd0, 6'd0);
        wait_idle();
        chk("resop_fe_pulses", fe_cnt - fe0, 2);
        chk("resop_count", got.size(), 16);
        if (got.size() == 16) begin
            chk("resop_prev_no_eop", got[7].eop, 0);
            chk("resop_new_byte", got[8].d, 8'hB0);
            chk("resop_new_sop", got[8].sop, 1);
        end

        // Error carried on eop byte only
        got.delete(); got_cyc.delete();
        send(64'h3031323334353637, 1'b1, 1'b0, 3'd0, 6'd0);
        send(64'h38393A3B3C3D3E3F, 1'b0, 1'b1, 3'd2, 6'h21);
        wait_idle();
        chk("err_count", got.size(), 14);
        if (got.size() == 14) begin
            chk("err_eop_error", got[13].err, 6'h21);
            chk("err_eop_byte", got[13].d, 8'h3D);
            nerr = 0;
            for (int i = 0; i < 13; i++) if (got[i].err !== 6'd0) nerr++;
            chk("err_other_zero", nerr, 0);
        end

        // Reset in the middle of a beat
        got.delete(); got_cyc.delete();
        send(64'h4041424344454647, 1'b1, 1'b0, 3'd0, 6'd0);
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(posedge clk);
            if (got.size() >= 3) hit = 1'b1;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL midrst_wait: %0d bytes emitted, required 3", got.size());
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", aso_out_valid, 0);
        chk("midrst_ready", asi_in_ready, 1);
`ifdef AST_DOWNCONV_STATS_EN
        chk("midrst_pkt_count", pkt_count, 0);
`endif
        @(posedge clk);
        #1;
        got.delete(); got_cyc.delete();
        fe0 = fe_cnt;
        send(64'h5555555555555555, 1'b0, 1'b0, 3'd0, 6'd0);
        wait_idle();
        chk("postrst_orphan_fe", fe_cnt - fe0, 1);
        chk("postrst_orphan_bytes", got.size(), 0);
        send(64'hEE00000000000000, 1'b1, 1'b1, 3'd7, 6'h3F);
        wait_idle();
        chk("onebyte_count", got.size(), 1);
        if (got.size() == 1) begin
            chk("onebyte_data", got[0].d, 8'hEE);
            chk("onebyte_sop_eop", {got[0].sop, got[0].eop}, 2'b11);
            chk("onebyte_err", got[0].err, 6'h3F);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
